// File: rtl/hamming_pkg.sv
`default_nettype none
// ==========================================================================
// hamming_pkg: widths, bit positions, injection codes and SECDED encode
// Rev 1.0
// ==========================================================================
package hamming_pkg;

  localparam int c_DATA_W = 7;
  localparam int c_CODE_W = 12;

  localparam int c_POS_D1 = 3;
  localparam int c_POS_D2 = 5;
  localparam int c_POS_D3 = 6;
  localparam int c_POS_D4 = 7;
  localparam int c_POS_D5 = 9;
  localparam int c_POS_D6 = 10;
  localparam int c_POS_D7 = 11;

  localparam logic [1:0] c_INJ_NONE   = 2'd0;
  localparam logic [1:0] c_INJ_SINGLE = 2'd1;
  localparam logic [1:0] c_INJ_DOUBLE = 2'd2;
  localparam logic [1:0] c_INJ_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  function automatic logic [c_CODE_W:1] hamming_encode(input logic [c_DATA_W:1] d);
    logic [c_CODE_W:1] c;
    c           = '0;
    c[c_POS_D1] = d[1];
    c[c_POS_D2] = d[2];
    c[c_POS_D3] = d[3];
    c[c_POS_D4] = d[4];
    c[c_POS_D5] = d[5];
    c[c_POS_D6] = d[6];
    c[c_POS_D7] = d[7];
    c[1]        = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2]        = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4]        = c[5] ^ c[6] ^ c[7];
    c[8]        = c[9] ^ c[10] ^ c[11];
    // Overall parity makes the full 12-bit word even.
    c[12]       = ^c[11:1];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_secded_enc_stream_if.sv
`default_nettype none
// ==========================================================================
// hamming_secded_enc_stream_if: input/output stream bundle of the encoder
// Rev 1.0 -- inj_mode/inj_pos present only with HAMMING_ERR_INJ_EN
// ==========================================================================
interface hamming_secded_enc_stream_if #(
  parameter int CNT_W = 16
);
  import hamming_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [c_DATA_W:1]   s_data;
  logic                m_valid;
  logic                m_ready;
  logic [c_CODE_W:1]   m_code;
  logic [CNT_W-1:0]    word_cnt;
`ifdef HAMMING_ERR_INJ_EN
  logic [1:0]          inj_mode;
  logic [3:0]          inj_pos;

  modport master (
    output s_valid, s_data, m_ready, inj_mode, inj_pos,
    input  s_ready, m_valid, m_code, word_cnt
  );
  modport slave (
    input  s_valid, s_data, m_ready, inj_mode, inj_pos,
    output s_ready, m_valid, m_code, word_cnt
  );
`else
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_code, word_cnt
  );
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_code, word_cnt
  );
`endif

endinterface
`default_nettype wire

// File: rtl/hamming_enc_core.sv
`default_nettype none
// ==========================================================================
// hamming_enc_core: combinational SECDED(12,7) encode with optional
// error injection (HAMMING_ERR_INJ_EN). Rev 1.0
// ==========================================================================
module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [c_DATA_W:1] i_data,
`ifdef HAMMING_ERR_INJ_EN
  input  logic [1:0]        i_inj_mode,
  input  logic [3:0]        i_inj_pos,
`endif
  output logic [c_CODE_W:1] o_code
);

  logic [c_CODE_W:1] w_clean;
  logic [c_CODE_W:1] w_flip;

  assign w_clean = hamming_encode(i_data);

`ifdef HAMMING_ERR_INJ_EN
  logic [c_CODE_W:1] w_pos_hot;

  // Positions outside 1..12 decode to an all-zero mask, so they flip nothing.
  always_comb begin
    w_pos_hot = '0;
    for (int i = 1; i <= c_CODE_W; i++) begin
      if (i_inj_pos == 4'(i)) w_pos_hot[i] = 1'b1;
    end
  end

  always_comb begin
    w_flip = '0;
    case (i_inj_mode)
      c_INJ_SINGLE: w_flip = w_pos_hot;
      c_INJ_DOUBLE: w_flip = (|w_pos_hot) ? (w_pos_hot | {1'b1, 11'b0}) : '0;
      c_INJ_NONE,
      c_INJ_RSVD:   w_flip = '0;
    endcase
  end
`else
  assign w_flip = '0;
`endif

  assign o_code = w_clean ^ w_flip;

endmodule
`default_nettype wire

// File: rtl/hamming_secded_enc_stream.sv
`default_nettype none
// ==========================================================================
// hamming_secded_enc_stream: streaming SECDED encoder, 2-entry output buffer
// Rev 1.0 -- optional error injection via HAMMING_ERR_INJ_EN
// ==========================================================================
module hamming_secded_enc_stream
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic                        clk,
  input  logic                        rst,
  hamming_secded_enc_stream_if.slave  bus
);

  occ_state_t        r_state;
  logic [c_CODE_W:1] r_head;
  logic [c_CODE_W:1] r_tail;
  logic              r_m_valid;
  logic [CNT_W-1:0]  r_word_cnt;

  logic [c_CODE_W:1] w_enc;
  logic              w_s_ready;
  logic              w_push;
  logic              w_pop;

  hamming_enc_core u_core (
    .i_data     (bus.s_data),
`ifdef HAMMING_ERR_INJ_EN
    .i_inj_mode (bus.inj_mode),
    .i_inj_pos  (bus.inj_pos),
`endif
    .o_code     (w_enc)
  );

  // Ready depends on occupancy only; rst gating keeps it low while in reset.
  assign w_s_ready = !rst && (r_state != OCC_FULL);
  assign w_push    = bus.s_valid && w_s_ready;
  assign w_pop     = r_m_valid && bus.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_head     <= '0;
      r_tail     <= '0;
      r_m_valid  <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_push) r_word_cnt <= r_word_cnt + CNT_W'(1);
      case (r_state)
        OCC_EMPTY: begin
          if (w_push) begin
            r_head    <= w_enc;
            r_m_valid <= 1'b1;
            r_state   <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_enc;
          end else if (w_push) begin
            r_tail  <= w_enc;
            r_state <= OCC_FULL;
          end else if (w_pop) begin
            r_m_valid <= 1'b0;
            r_state   <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= OCC_ONE;
          end
        end
        default: begin
          r_m_valid <= 1'b0;
          r_state   <= OCC_EMPTY;
        end
      endcase
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_code   = r_head;
  assign bus.word_cnt = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_enc_stream.sv
`default_nettype none
// ==========================================================================
// tb_hamming_secded_enc_stream: directed self-checking bench for the encoder
// Rev 1.0
// ==========================================================================
module tb_hamming_secded_enc_stream;
  import hamming_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming_secded_enc_stream_if #(.CNT_W(16)) bus ();
  hamming_secded_enc_stream_if #(.CNT_W(4))  bus4 ();

  hamming_secded_enc_stream #(.CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  hamming_secded_enc_stream #(.CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decoder: {syndrome[3:0], overall parity, extracted data[7:1]}
  function automatic logic [11:0] decode(input logic [12:1] c);
    logic [3:0] syn;
    logic       par;
    logic [7:1] d;
    syn = '0;
    for (int i = 1; i <= 11; i++) begin
      if (c[i]) syn = syn ^ 4'(i);
    end
    par = ^c;
    d   = {c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
    return {syn, par, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] w_dec;
    rst           = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
    bus4.s_valid  = 1'b0;
    bus4.s_data   = '0;
    bus4.m_ready  = 1'b1;
`ifdef HAMMING_ERR_INJ_EN
    bus.inj_mode  = 2'd0;
    bus.inj_pos   = 4'd0;
    bus4.inj_mode = 2'd0;
    bus4.inj_pos  = 4'd0;
`endif
    repeat (3) tick();
    chk_eq("rst_m_valid",  bus.m_valid,  0);
    chk_eq("rst_m_code",   bus.m_code,   0);
    chk_eq("rst_word_cnt", bus.word_cnt, 0);
    chk_eq("rst_s_ready",  bus.s_ready,  0);

    rst = 1'b0;
    #1;
    chk_eq("post_rst_s_ready", bus.s_ready, 1);
    chk_eq("post_rst_m_valid", bus.m_valid, 0);

    // Basic vectors, continuous ready
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 7'h01;
    tick();
    chk_eq("enc01_valid", bus.m_valid,  1);
    chk_eq("enc01_code",  bus.m_code,   12'h807);
    chk_eq("enc01_cnt",   bus.word_cnt, 1);
    bus.s_data = 7'h7F;
    tick();
    chk_eq("enc7F_code", bus.m_code,   12'hFFF);
    chk_eq("enc7F_cnt",  bus.word_cnt, 2);
    bus.s_data = 7'h00;
    tick();
    chk_eq("enc00_valid", bus.m_valid, 1);
    chk_eq("enc00_code",  bus.m_code,  12'h000);
    bus.s_valid = 1'b0;
    tick();
    chk_eq("drain_valid", bus.m_valid,  0);
    chk_eq("drain_cnt",   bus.word_cnt, 3);

    // All 128 data words, back to back, each checked through the reference decoder
    for (int d = 0; d < 128; d++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 7'(d);
      tick();
      w_dec = decode(bus.m_code);
      chk_eq("exhaustive", {bus.m_valid, w_dec}, {1'b1, 4'd0, 1'b0, 7'(d)});
    end
    bus.s_valid = 1'b0;
    tick();
    chk_eq("exh_cnt", bus.word_cnt, 131);

    // Backpressure: two absorbed, third held off
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 7'h11;
    tick();
    chk_eq("bp_one_ready", bus.s_ready, 1);
    bus.s_data = 7'h22;
    tick();
    chk_eq("bp_full_ready", bus.s_ready, 0);
    chk_eq("bp_head_a",     bus.m_code,  12'h186);
    bus.s_data = 7'h33;
    repeat (2) tick();
    chk_eq("bp_hold_code",  bus.m_code,   12'h186);
    chk_eq("bp_hold_valid", bus.m_valid,  1);
    chk_eq("bp_hold_cnt",   bus.word_cnt, 133);
    chk_eq("bp_hold_ready", bus.s_ready,  0);
    bus.m_ready = 1'b1;
    tick();
    chk_eq("bp_pop1_code",  bus.m_code,   12'h29B);
    chk_eq("bp_pop1_ready", bus.s_ready,  1);
    chk_eq("bp_pop1_cnt",   bus.word_cnt, 133);
    tick();
    chk_eq("bp_pop2_code", bus.m_code,   12'h31D);
    chk_eq("bp_pop2_cnt",  bus.word_cnt, 134);
    bus.s_valid = 1'b0;
    tick();
    chk_eq("bp_empty", bus.m_valid, 0);

`ifdef HAMMING_ERR_INJ_EN
    bus.s_valid  = 1'b1;
    bus.s_data   = 7'h01;
    bus.inj_mode = 2'd1;
    bus.inj_pos  = 4'd5;
    tick();
    chk_eq("inj_single_code", bus.m_code, 12'h817);
    w_dec = decode(bus.m_code);
    chk_eq("inj_single_dec", w_dec[11:7], {4'd5, 1'b1});
    bus.inj_mode = 2'd2;
    tick();
    chk_eq("inj_double_code", bus.m_code, 12'h017);
    w_dec = decode(bus.m_code);
    chk_eq("inj_double_dec", w_dec[11:7], {4'd5, 1'b0});
    bus.inj_mode = 2'd3;
    tick();
    chk_eq("inj_rsvd_code", bus.m_code, 12'h807);
    bus.inj_mode = 2'd1;
    bus.inj_pos  = 4'd0;
    tick();
    chk_eq("inj_pos0_code", bus.m_code, 12'h807);
    bus.inj_pos = 4'd13;
    tick();
    chk_eq("inj_pos13_code", bus.m_code, 12'h807);
    bus.inj_mode = 2'd2;
    bus.inj_pos  = 4'd12;
    tick();
    chk_eq("inj_double_pos12", bus.m_code, 12'h007);
    bus.inj_mode = 2'd0;
    bus.inj_pos  = 4'd0;
    bus.s_valid  = 1'b0;
    tick();
`endif

    // Reset while the buffer is full
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 7'h11;
    tick();
    bus.s_data = 7'h22;
    tick();
    chk_eq("rstfull_pre_ready", bus.s_ready, 0);
    bus.s_valid = 1'b0;
    rst         = 1'b1;
    tick();
    chk_eq("rstfull_m_valid", bus.m_valid,  0);
    chk_eq("rstfull_cnt",     bus.word_cnt, 0);
    chk_eq("rstfull_code",    bus.m_code,   0);
    rst         = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("rstfull_no_stale", bus.m_valid, 0);
    end

    // Narrow counter wraps
    bus4.s_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      bus4.s_data = 7'(i);
      tick();
      if (i == 15) chk_eq("cnt4_max", bus4.word_cnt, 15);
      if (i == 16) chk_eq("cnt4_wrap", bus4.word_cnt, 0);
    end
    bus4.s_valid = 1'b0;
    tick();
    chk_eq("cnt4_17", bus4.word_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
